// File: rtl/up_counter_mod_if.sv
// Control/status bundle for the modulo-N up counter.
// Master drives control; slave is the counter.
interface up_counter_mod_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             stop;
  logic             en;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             tc;
  logic             wrap;
  logic             done;
  logic             load_err;

  modport master (
    output start, stop, en, clear, load, load_val,
    input  count, running, tc, wrap, done, load_err
  );

  modport slave (
    input  start, stop, en, clear, load, load_val,
    output count, running, tc, wrap, done, load_err
  );
endinterface

// File: rtl/up_counter_mod.sv
// Synchronous modulo-N up counter with start/stop,
// parallel load, terminal-count/wrap flags and one-shot mode.
module up_counter_mod #(
  parameter int WIDTH   = 3,
  parameter int MOD     = 8,
  parameter int ONESHOT = 0
) (
  input  logic               clk,
  input  logic               reset,
  up_counter_mod_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             err_q;

  logic at_max;
  logic inc;
  logic load_ok;

  assign at_max  = (count_q == MAX);
  assign inc     = (state_q == S_RUN) && bus.en
                   && !bus.clear && !bus.load;
  assign load_ok = ({1'b0, bus.load_val} < MOD_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;

      // count priority: clear > load > increment
      if (bus.clear) begin
        count_q <= '0;
        err_q   <= 1'b0;
      end else if (bus.load) begin
        if (load_ok) begin
          count_q <= bus.load_val;
        end else begin
          count_q <= '0;
          err_q   <= 1'b1;
        end
      end else if (inc) begin
        if (!at_max) begin
          count_q <= count_q + WIDTH'(1);
        end else if (ONESHOT == 0) begin
          count_q <= '0;
          wrap_q  <= 1'b1;
        end
      end else if (state_q == S_DONE
                   && bus.start && !bus.stop) begin
        count_q <= '0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.stop)
            state_q <= S_RUN;
        end
        S_RUN: begin
          if (bus.stop)
            state_q <= S_IDLE;
          else if (ONESHOT != 0 && inc && at_max)
            state_q <= S_DONE;
        end
        S_DONE: begin
          if (bus.start && !bus.stop)
            state_q <= S_RUN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.count    = count_q;
  assign bus.running  = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
  assign bus.tc       = at_max && bus.running && bus.en;

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench: free-running MOD=6 counter (a)
// and one-shot MOD=4 counter (b), both WIDTH=3.
module tb_up_counter_mod;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  up_counter_mod_if #(.WIDTH(3)) ifa ();
  up_counter_mod_if #(.WIDTH(3)) ifb ();

  up_counter_mod #(
    .WIDTH(3), .MOD(6), .ONESHOT(0)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );

  up_counter_mod #(
    .WIDTH(3), .MOD(4), .ONESHOT(1)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ifa.start = 0; ifa.stop = 0; ifa.en = 0;
    ifa.clear = 0; ifa.load = 0; ifa.load_val = 0;
    ifb.start = 0; ifb.stop = 0; ifb.en = 0;
    ifb.clear = 0; ifb.load = 0; ifb.load_val = 0;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1;
    #2;
    checks++;
    if ({ifa.count, ifa.running, ifa.wrap, ifa.tc, ifa.load_err}
        !== 7'd0) begin
      errors++;
      $display("FAIL reset_a: got count=%0d run=%0b wrap=%0b tc=%0b err=%0b want all 0",
               ifa.count, ifa.running, ifa.wrap, ifa.tc, ifa.load_err);
    end
    checks++;
    if ({ifb.count, ifb.running, ifb.done, ifb.load_err}
        !== 6'd0) begin
      errors++;
      $display("FAIL reset_b: got count=%0d run=%0b done=%0b err=%0b want all 0",
               ifb.count, ifb.running, ifb.done, ifb.load_err);
    end
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_free_run();
    logic [2:0] exp_c [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    ifa.start = 1; ifa.en = 1;
    tick();
    ifa.start = 0;
    checks++;
    if (ifa.running !== 1'b1 || ifa.count !== 3'd0) begin
      errors++;
      $display("FAIL fr_start: got run=%0b count=%0d want run=1 count=0",
               ifa.running, ifa.count);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ifa.tc !== (i == 5)) begin
        errors++;
        $display("FAIL fr_tc[%0d]: got %0b want %0b",
                 i, ifa.tc, (i == 5));
      end
      tick();
      checks++;
      if (ifa.count !== exp_c[i] || ifa.wrap !== (i == 5)) begin
        errors++;
        $display("FAIL fr_step[%0d]: got count=%0d wrap=%0b want count=%0d wrap=%0b",
                 i, ifa.count, ifa.wrap, exp_c[i], (i == 5));
      end
    end
    tick();
    checks++;
    if (ifa.count !== 3'd1 || ifa.wrap !== 1'b0) begin
      errors++;
      $display("FAIL fr_wrap_once: got count=%0d wrap=%0b want count=1 wrap=0",
               ifa.count, ifa.wrap);
    end
  endtask

  task automatic test_reset_mid();
    repeat (4) tick();
    checks++;
    if (ifa.count !== 3'd5) begin
      errors++;
      $display("FAIL mid_pre: got count=%0d want 5", ifa.count);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (ifa.count !== 3'd0 || ifa.running !== 1'b0
        || ifa.tc !== 1'b0 || ifa.wrap !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got count=%0d run=%0b tc=%0b wrap=%0b want 0",
               ifa.count, ifa.running, ifa.tc, ifa.wrap);
    end
    #1 reset = 0;
    quiet();
    tick();
    checks++;
    if (ifa.running !== 1'b0 || ifa.count !== 3'd0) begin
      errors++;
      $display("FAIL mid_idle: got run=%0b count=%0d want run=0 count=0",
               ifa.running, ifa.count);
    end
  endtask

  task automatic test_oneshot();
    ifb.start = 1; ifb.en = 1;
    tick();
    ifb.start = 0;
    repeat (3) tick();
    checks++;
    if (ifb.count !== 3'd3 || ifb.tc !== 1'b1) begin
      errors++;
      $display("FAIL os_tc: got count=%0d tc=%0b want count=3 tc=1",
               ifb.count, ifb.tc);
    end
    tick();
    checks++;
    if (ifb.count !== 3'd3 || ifb.done !== 1'b1
        || ifb.running !== 1'b0 || ifb.wrap !== 1'b0) begin
      errors++;
      $display("FAIL os_done: got count=%0d done=%0b run=%0b wrap=%0b want 3,1,0,0",
               ifb.count, ifb.done, ifb.running, ifb.wrap);
    end
    tick();
    checks++;
    if (ifb.count !== 3'd3 || ifb.done !== 1'b1) begin
      errors++;
      $display("FAIL os_hold: got count=%0d done=%0b want 3,1",
               ifb.count, ifb.done);
    end
    ifb.start = 1;
    tick();
    ifb.start = 0; ifb.en = 0;
    checks++;
    if (ifb.count !== 3'd0 || ifb.running !== 1'b1
        || ifb.done !== 1'b0) begin
      errors++;
      $display("FAIL os_restart: got count=%0d run=%0b done=%0b want 0,1,0",
               ifb.count, ifb.running, ifb.done);
    end
    ifb.stop = 1;
    tick();
    ifb.stop = 0;
  endtask

  task automatic test_load();
    logic [2:0] vals [4] = '{3'd4, 3'd7, 3'd5, 3'd6};
    logic [2:0] expc [4] = '{3'd4, 3'd0, 3'd5, 3'd0};
    logic       expe [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      ifa.load = 1; ifa.load_val = vals[i];
      tick();
      checks++;
      if (ifa.count !== expc[i] || ifa.load_err !== expe[i]) begin
        errors++;
        $display("FAIL load[%0d]: got count=%0d err=%0b want count=%0d err=%0b",
                 i, ifa.count, ifa.load_err, expc[i], expe[i]);
      end
    end
    ifa.load = 0; ifa.clear = 1;
    tick();
    ifa.clear = 0;
    checks++;
    if (ifa.load_err !== 1'b0 || ifa.count !== 3'd0) begin
      errors++;
      $display("FAIL load_clear: got count=%0d err=%0b want 0,0",
               ifa.count, ifa.load_err);
    end
  endtask

  task automatic test_priority();
    ifa.load = 1; ifa.load_val = 3'd3;
    tick();
    ifa.load = 0; ifa.start = 1; ifa.en = 1;
    tick();
    ifa.start = 0;
    checks++;
    if (ifa.count !== 3'd3 || ifa.running !== 1'b1) begin
      errors++;
      $display("FAIL pri_run: got count=%0d run=%0b want 3,1",
               ifa.count, ifa.running);
    end
    ifa.clear = 1; ifa.load = 1; ifa.load_val = 3'd2;
    tick();
    ifa.clear = 0; ifa.load = 0;
    checks++;
    if (ifa.count !== 3'd0) begin
      errors++;
      $display("FAIL pri_clear: got count=%0d want 0", ifa.count);
    end
    ifa.stop = 1;
    tick();
    checks++;
    if (ifa.count !== 3'd1 || ifa.running !== 1'b0) begin
      errors++;
      $display("FAIL pri_stop: got count=%0d run=%0b want 1,0",
               ifa.count, ifa.running);
    end
    ifa.start = 1;
    tick();
    ifa.start = 0; ifa.stop = 0;
    checks++;
    if (ifa.running !== 1'b0 || ifa.count !== 3'd1) begin
      errors++;
      $display("FAIL pri_startstop: got run=%0b count=%0d want 0,1",
               ifa.running, ifa.count);
    end
  endtask

  task automatic test_en_gating();
    ifa.start = 1; ifa.en = 1;
    tick();
    ifa.start = 0;
    tick();
    checks++;
    if (ifa.count !== 3'd2) begin
      errors++;
      $display("FAIL en_on: got count=%0d want 2", ifa.count);
    end
    ifa.en = 0;
    tick();
    checks++;
    if (ifa.count !== 3'd2 || ifa.running !== 1'b1) begin
      errors++;
      $display("FAIL en_off: got count=%0d run=%0b want 2,1",
               ifa.count, ifa.running);
    end
    ifa.load = 1; ifa.load_val = 3'd4; ifa.en = 1;
    tick();
    ifa.load = 0;
    tick();
    ifa.en = 0;
    #1;
    checks++;
    if (ifa.count !== 3'd5 || ifa.tc !== 1'b0) begin
      errors++;
      $display("FAIL en_tc_off: got count=%0d tc=%0b want 5,0",
               ifa.count, ifa.tc);
    end
    tick();
    ifa.en = 1;
    #1;
    checks++;
    if (ifa.count !== 3'd5 || ifa.tc !== 1'b1) begin
      errors++;
      $display("FAIL en_tc_on: got count=%0d tc=%0b want 5,1",
               ifa.count, ifa.tc);
    end
    tick();
    checks++;
    if (ifa.count !== 3'd0 || ifa.wrap !== 1'b1) begin
      errors++;
      $display("FAIL en_wrap: got count=%0d wrap=%0b want 0,1",
               ifa.count, ifa.wrap);
    end
  endtask

  task automatic test_back_to_back();
    ifb.start = 1; ifb.en = 1; ifb.load = 1; ifb.load_val = 3'd3;
    tick();
    ifb.start = 0; ifb.load = 0;
    checks++;
    if (ifb.count !== 3'd3 || ifb.running !== 1'b1) begin
      errors++;
      $display("FAIL b2b_loadstart: got count=%0d run=%0b want 3,1",
               ifb.count, ifb.running);
    end
    tick();
    ifb.en = 0;
    checks++;
    if (ifb.done !== 1'b1 || ifb.count !== 3'd3) begin
      errors++;
      $display("FAIL b2b_done: got done=%0b count=%0d want 1,3",
               ifb.done, ifb.count);
    end
    ifb.clear = 1;
    tick();
    ifb.clear = 0;
    checks++;
    if (ifb.count !== 3'd0 || ifb.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_clear_done: got count=%0d done=%0b want 0,1",
               ifb.count, ifb.done);
    end
    ifb.load = 1; ifb.load_val = 3'd5;
    tick();
    ifb.load = 0;
    checks++;
    if (ifb.count !== 3'd0 || ifb.load_err !== 1'b1
        || ifb.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_loaderr: got count=%0d err=%0b done=%0b want 0,1,1",
               ifb.count, ifb.load_err, ifb.done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1;
    test_reset();
    test_free_run();
    test_reset_mid();
    test_oneshot();
    quiet();
    test_load();
    test_priority();
    quiet();
    test_en_gating();
    quiet();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
